// File: rtl/negation_scheduler.sv
// Round-robin arbiter in front of one shared two's-complement negator (~x + 1).
// Three-state handshake: grant/capture, compute, hold result until consumed.
module negation_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_operand,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [ID_W-1:0]          resp_id,
  output logic                     resp_ovf,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, COMPUTE, RESPOND} state_t;

  state_t                  state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         grant_idx;
  logic                    grant_vld;
  logic [ID_W:0]           idx;
  logic signed [WIDTH-1:0] op_p0;
  logic [ID_W-1:0]         id_p0;

  function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // The most negative value is its own negation; flag it rather than saturate.
  function automatic logic is_most_neg(input logic signed [WIDTH-1:0] x);
    return x == {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  // Walk from farthest to nearest so the nearest valid requester after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NUM_REQ))
        idx = idx - (ID_W+1)'(NUM_REQ);
      if (req_valid[idx[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld)
      req_ready = NUM_REQ'(1) << grant_idx;
  end

  assign busy = (state != IDLE);

  // p0: operand capture on the grant cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_vld) begin
      op_p0 <= req_operand[grant_idx*WIDTH +: WIDTH];
      id_p0 <= grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ-1);
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            rr_ptr <= grant_idx;
            state  <= COMPUTE;
          end
        end
        // p1: negation result registered onto the response port
        COMPUTE: begin
          resp_data  <= negate(op_p0);
          resp_ovf   <= is_most_neg(op_p0);
          resp_id    <= id_p0;
          resp_valid <= 1'b1;
          state      <= RESPOND;
        end
        RESPOND: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_negation_scheduler.sv
// Directed-vector bench for negation_scheduler: reset, arithmetic corners,
// round-robin order, response back-pressure and mid-operation reset.
module tb_negation_scheduler;
  localparam int WIDTH = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W = 2;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_operand;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_data;
  logic [ID_W-1:0]          resp_id;
  logic                     resp_ovf;
  logic                     busy;

  int n_checks = 0;
  int n_fail   = 0;

  negation_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_operand(req_operand),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_ovf(resp_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    req_operand = '0;
    resp_ready = 1'b0;
    #2;
    n_checks++;
    if ({req_ready, resp_valid, resp_data, resp_id, resp_ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h id=%0d ovf=%b busy=%b, want all 0",
               req_ready, resp_valid, resp_data, resp_id, resp_ovf, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: got busy=%b rdy=%b, want 0 0000", busy, req_ready);
    end
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    req_operand[0 +: WIDTH] = 32'h0000_0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b, want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_compute: got vld=%b busy=%b rdy=%b, want 0 1 0000",
               resp_valid, busy, req_ready);
    end
    tick();
    n_checks++;
    if (resp_valid !== 1'b1 || resp_data !== 32'hFFFF_FFFF || resp_id !== 2'd0 || resp_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: got vld=%b data=%h id=%0d ovf=%b, want 1 ffffffff 0 0",
               resp_valid, resp_data, resp_id, resp_ovf);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL single_done: got vld=%b busy=%b data=%h, want 0 0 ffffffff",
               resp_valid, busy, resp_data);
    end
  endtask

  // Drive one request and collect the response; a timeout reports FAIL.
  task automatic run_op(input int id, input logic [WIDTH-1:0] op,
                        output logic [WIDTH-1:0] d, output logic [ID_W-1:0] rid,
                        output logic ovf);
    int waited;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_operand[id*WIDTH +: WIDTH] = op;
    resp_ready = 1'b1;
    tick();
    req_valid = '0;
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    d = resp_data;
    rid = resp_id;
    ovf = resp_ovf;
    if (waited >= 8) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_op_timeout: got no resp_valid after %0d cycles, want response", waited);
    end
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_arith();
    logic [WIDTH-1:0] ops [4] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_00FF};
    logic [WIDTH-1:0] exp [4] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0001, 32'hFFFF_FF01};
    logic             eovf [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int               ids [4] = '{1, 3, 2, 0};
    logic [WIDTH-1:0] d;
    logic [ID_W-1:0]  rid;
    logic             ovf;
    for (int i = 0; i < 4; i++) begin
      run_op(ids[i], ops[i], d, rid, ovf);
      n_checks++;
      if (d !== exp[i] || ovf !== eovf[i] || rid !== ID_W'(ids[i])) begin
        n_fail++;
        $display("FAIL arith_%0d: got data=%h ovf=%b id=%0d, want %h %b %0d",
                 i, d, ovf, rid, exp[i], eovf[i], ids[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [WIDTH-1:0] ops [4] = '{32'h0000_0005, 32'h0000_0010, 32'h7FFF_FFFF, 32'h0000_0100};
    logic [WIDTH-1:0] exp [4] = '{32'hFFFF_FFFB, 32'hFFFF_FFF0, 32'h8000_0001, 32'hFFFF_FF00};
    logic [NUM_REQ-1:0] want;
    int g;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NUM_REQ; i++) req_operand[i*WIDTH +: WIDTH] = ops[i];
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      g = (c / 3) % 4;
      want = (c % 3 == 0) ? (4'b0001 << g) : 4'b0000;
      n_checks++;
      if (req_ready !== want) begin
        n_fail++;
        $display("FAIL rr_ready_c%0d: got %b, want %b", c, req_ready, want);
      end
      if (c % 3 == 2) begin
        n_checks++;
        if (resp_valid !== 1'b1 || resp_id !== ID_W'(g) || resp_data !== exp[g]) begin
          n_fail++;
          $display("FAIL rr_resp_c%0d: got vld=%b id=%0d data=%h, want 1 %0d %h",
                   c, resp_valid, resp_id, resp_data, g, exp[g]);
        end
      end
      tick();
    end
    req_valid = '0;
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    req_operand[1*WIDTH +: WIDTH] = 32'h1234_5678;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'hEDCB_A988 || resp_id !== 2'd1 ||
          resp_ovf !== 1'b0 || busy !== 1'b1 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL hold_c%0d: got vld=%b data=%h id=%0d ovf=%b busy=%b rdy=%b, want 1 edcba988 1 0 1 0000",
                 c, resp_valid, resp_data, resp_id, resp_ovf, busy, req_ready);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0100 || resp_data !== 32'hEDCB_A988) begin
      n_fail++;
      $display("FAIL hold_release: got vld=%b busy=%b rdy=%b data=%h, want 0 0 0100 edcba988",
               resp_valid, busy, req_ready, resp_data);
    end
    req_valid = '0;
    resp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    int waited;
    req_operand[2*WIDTH +: WIDTH] = 32'h0000_0003;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got busy=%b, want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || resp_data !== '0 || resp_id !== '0 ||
        resp_ovf !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_values: got vld=%b busy=%b data=%h id=%0d ovf=%b rdy=%b, want all 0",
               resp_valid, busy, resp_data, resp_id, resp_ovf, req_ready);
    end
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_grant: got %b, want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    resp_ready = 1'b1;
    waited = 0;
    while (resp_valid !== 1'b1 && waited < 8) begin
      tick();
      waited++;
    end
    n_checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin
      n_fail++;
      $display("FAIL midrst_resp: got vld=%b id=%0d, want 1 0", resp_valid, resp_id);
    end
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1);
  end
endmodule
